// File: rtl/handshake_constant_burst_pkg.sv
// handshake_constant_burst_pkg: FSM state encoding and width helper shared by the burst source
package handshake_constant_burst_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/handshake_out_reg.sv
// handshake_out_reg: one-slot registered output buffer
//   load/data in      : write data into the slot (caller only loads when slot_free)
//   outs_ready in     : consumer ready
//   slot_free out     : slot empty or draining this cycle
//   outs/outs_valid   : registered output token
module handshake_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  outs_ready,
    output logic                  slot_free,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid
);

    always_comb slot_free = !outs_valid || outs_ready;

    // a load wins over a drain, so a transfer plus reload keeps valid high with no bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            outs       <= '0;
            outs_valid <= 1'b0;
        end else if (load) begin
            outs       <= data;
            outs_valid <= 1'b1;
        end else if (outs_ready) begin
            outs_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_constant_burst.sv
// handshake_constant_burst: each ctrl token emits BURST tokens VALUE, VALUE+STRIDE, ...
//   clk/rst             : clock, synchronous active-high reset
//   ctrl_valid/ready    : dataless trigger channel
//   outs/valid/ready    : registered data output channel
module handshake_constant_burst
    import handshake_constant_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VALUE      = 0,
    parameter int STRIDE     = 0,
    parameter int BURST      = 1,
    parameter int RESTART    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int REM_W = clog2(BURST) < 1 ? 1 : clog2(BURST);
    localparam logic [DATA_WIDTH-1:0] VAL      = DATA_WIDTH'(VALUE);
    localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(STRIDE);
    localparam logic [REM_W-1:0]      LAST_REM = REM_W'(BURST - 1);

    if (BURST < 1) begin : g_bad_burst
        $error("handshake_constant_burst: BURST must be >= 1");
    end

    state_t           state;
    logic [DATA_WIDTH-1:0] cur;
    logic [REM_W-1:0] rem;
    logic             slot_free;
    logic             load;
    logic             last;

    always_comb begin
        ctrl_ready = state == ST_IDLE && slot_free && !rst;
        load       = state == ST_IDLE ? ctrl_valid && ctrl_ready : slot_free;
        // in IDLE the first load is also the last only for single-token bursts
        last       = state == ST_IDLE ? BURST == 1 : rem == REM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cur   <= VAL;
            rem   <= '0;
        end else if (load) begin
            cur   <= last && RESTART != 0 ? VAL : cur + STEP;
            rem   <= state == ST_IDLE ? LAST_REM : rem - REM_W'(1);
            state <= last ? ST_IDLE : ST_BURST;
        end
    end

    handshake_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (cur),
        .outs_ready (outs_ready),
        .slot_free  (slot_free),
        .outs       (outs),
        .outs_valid (outs_valid)
    );

endmodule

// File: tb/tb_handshake_constant_burst.sv
// tb_handshake_constant_burst: random traffic on four configurations against a token-queue model
module tb_handshake_constant_burst;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // config fields: 0 width, 1 value, 2 stride, 3 burst, 4 restart
    function automatic int cfg(input int g, input int f);
        int t[5];
        case (g)
            0:       t = '{32, 5, 2, 4, 1};
            1:       t = '{8, 250, 3, 2, 0};
            2:       t = '{32, 3, 0, 1, 1};
            default: t = '{4, 10, 1, 3, 0};
        endcase
        return t[f];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        localparam int DW = cfg(g, 0);
        localparam int V  = cfg(g, 1);
        localparam int S  = cfg(g, 2);
        localparam int B  = cfg(g, 3);
        localparam int R  = cfg(g, 4);

        logic          cval = 1'b0;
        logic          ordy = 1'b0;
        logic          crdy;
        logic          ovld;
        logic [DW-1:0] outs;

        handshake_constant_burst #(
            .DATA_WIDTH (DW),
            .VALUE      (V),
            .STRIDE     (S),
            .BURST      (B),
            .RESTART    (R)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .ctrl_valid (cval),
            .ctrl_ready (crdy),
            .outs       (outs),
            .outs_valid (ovld),
            .outs_ready (ordy)
        );

        // model: tokens owed for the current burst, plus the visible output slot
        logic [DW-1:0] pend[$];
        bit            sv = 1'b0;
        logic [DW-1:0] sval = '0;
        int            k = 0;
        bit            in_rst = 1'b1;

        always @(posedge clk) begin
            bit free;
            bit fire;
            free   = !sv || ordy;
            fire   = cval && !rst && free && pend.size() == 0;
            in_rst = rst;
            if (rst) begin
                pend.delete();
                sv   = 1'b0;
                sval = '0;
                k    = 0;
            end else begin
                if (fire)
                    for (int i = 0; i < B; i++) begin
                        pend.push_back(DW'(longint'(V) + longint'(R != 0 ? i : k) * longint'(S)));
                        k++;
                    end
                if (free && pend.size() > 0) begin
                    sval = pend.pop_front();
                    sv   = 1'b1;
                end else if (sv && ordy) begin
                    sv = 1'b0;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            chk($sformatf("c%0d_outs_valid", g), 64'(ovld), 64'(sv));
            if (sv || in_rst) chk($sformatf("c%0d_outs", g), 64'(outs), 64'(sval));
            cval = $urandom_range(0, 2) != 0;
            ordy = $urandom_range(0, 3) != 0;
            #1;
            chk($sformatf("c%0d_ctrl_ready", g), 64'(crdy),
                64'(!rst && pend.size() == 0 && (!sv || ordy)));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst = $urandom_range(0, 79) == 0;
        end
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
